// File: rtl/sha1_pkg.sv
// Shared SHA-1 definitions: padder FSM states, block layout constants and the
// hash/round constants used by both the padder and the core.
package sha1_pkg;

    typedef enum logic [2:0] {
        S_FILL,
        S_EMIT,
        S_PAD,
        S_EMIT_PAD,
        S_EXTRA,
        S_EMIT_LAST
    } padder_state_t;

    localparam logic [7:0] PAD_BYTE    = 8'h80;
    localparam int         BLOCK_BYTES = 64;
    localparam int         LEN_OFFSET  = 56;

    localparam logic [31:0] H0 = 32'h67452301;
    localparam logic [31:0] H1 = 32'hEFCDAB89;
    localparam logic [31:0] H2 = 32'h98BADCFE;
    localparam logic [31:0] H3 = 32'h10325476;
    localparam logic [31:0] H4 = 32'hC3D2E1F0;

    localparam logic [31:0] K0 = 32'h5A827999;
    localparam logic [31:0] K1 = 32'h6ED9EBA1;
    localparam logic [31:0] K2 = 32'h8F1BBCDC;
    localparam logic [31:0] K3 = 32'hCA62C1D6;

    // Byte idx of the block (56..63) carries the big-endian bit length.
    function automatic logic [7:0] len_byte(input logic [63:0] bit_len, input int idx);
        return bit_len[8*((BLOCK_BYTES - 1 - idx) & 7) +: 8];
    endfunction

endpackage

// File: rtl/sha1_block_buffer.sv
// 64-byte staging buffer for one SHA-1 block: byte writes, 0x80/zero padding
// from a given index, length insertion, and a flattened big-endian read.
module sha1_block_buffer
    import sha1_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         wr_en,
    input  logic [5:0]   wr_idx,
    input  logic [7:0]   wr_data,
    input  logic         pad_en,
    input  logic [5:0]   pad_idx,
    input  logic         extra_en,
    input  logic [63:0]  bit_len,
    output logic [511:0] block
);

    logic [7:0] mem [BLOCK_BYTES];
    logic       pad_has_len;

    // The length only fits in this block if the 0x80 lands before the length field.
    assign pad_has_len = (pad_idx < 6'(LEN_OFFSET));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < BLOCK_BYTES; i++) mem[6'(i)] <= 8'h00;
        end else if (clear) begin
            for (int i = 0; i < BLOCK_BYTES; i++) mem[6'(i)] <= 8'h00;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_data;
        end else if (pad_en) begin
            for (int i = 0; i < BLOCK_BYTES; i++) begin
                if (i == int'(pad_idx))
                    mem[6'(i)] <= PAD_BYTE;
                else if (i > int'(pad_idx))
                    mem[6'(i)] <= (pad_has_len && i >= LEN_OFFSET) ? len_byte(bit_len, i) : 8'h00;
            end
        end else if (extra_en) begin
            for (int i = 0; i < BLOCK_BYTES; i++)
                mem[6'(i)] <= (i >= LEN_OFFSET) ? len_byte(bit_len, i) : 8'h00;
        end
    end

    for (genvar g = 0; g < BLOCK_BYTES; g++) begin : g_flat
        assign block[8*(BLOCK_BYTES-1-g) +: 8] = mem[g];
    end

endmodule

// File: rtl/sha1_padder.sv
// SHA-1 message padder: packs a byte stream into 512-bit blocks and appends
// the 0x80 marker, zero fill and 64-bit big-endian bit length.
module sha1_padder #(
    parameter int LEN_WIDTH   = 64,
    parameter int BLOCK_BYTES = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   byte_in,
    input  logic         byte_valid,
    input  logic         byte_last,
    input  logic         close,
    output logic         byte_ready,
    output logic [511:0] block_out,
    output logic         block_valid,
    output logic         block_last,
    input  logic         block_ready,
    output logic         busy
);
    import sha1_pkg::*;

    localparam int               PTR_W    = $clog2(BLOCK_BYTES);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BLOCK_BYTES - 1);

    padder_state_t        state;
    logic [PTR_W-1:0]     ptr;
    logic [LEN_WIDTH-1:0] bitcnt;
    logic                 pend_pad;
    logic                 take_byte;
    logic                 take_close;
    logic                 msg_end;
    logic                 handshake;

    assign take_byte  = (state == S_FILL) && byte_ready && byte_valid;
    assign take_close = (state == S_FILL) && byte_ready && close && !byte_valid;
    assign msg_end    = byte_last || close;
    assign handshake  = block_valid && block_ready;
    assign busy       = (state != S_FILL) || (ptr != '0) || (bitcnt != '0);

    sha1_block_buffer u_buffer (
        .clk      (clk),
        .reset    (reset),
        .clear    (handshake),
        .wr_en    (take_byte),
        .wr_idx   (ptr),
        .wr_data  (byte_in),
        .pad_en   (state == S_PAD),
        .pad_idx  (ptr),
        .extra_en (state == S_EXTRA),
        .bit_len  (bitcnt),
        .block    (block_out)
    );

    // Outputs are registered alongside the state so they change only on transitions.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_FILL;
            ptr         <= '0;
            bitcnt      <= '0;
            pend_pad    <= 1'b0;
            byte_ready  <= 1'b0;
            block_valid <= 1'b0;
            block_last  <= 1'b0;
        end else begin
            case (state)
                S_FILL: begin
                    byte_ready <= 1'b1;
                    if (take_byte) begin
                        ptr    <= ptr + PTR_W'(1);
                        bitcnt <= bitcnt + LEN_WIDTH'(8);
                        if (ptr == LAST_PTR) begin
                            state       <= S_EMIT;
                            pend_pad    <= msg_end;
                            byte_ready  <= 1'b0;
                            block_valid <= 1'b1;
                            block_last  <= 1'b0;
                        end else if (msg_end) begin
                            state      <= S_PAD;
                            byte_ready <= 1'b0;
                        end
                    end else if (take_close) begin
                        state      <= S_PAD;
                        byte_ready <= 1'b0;
                    end
                end
                S_EMIT: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        ptr         <= '0;
                        if (pend_pad) begin
                            state    <= S_PAD;
                            pend_pad <= 1'b0;
                        end else begin
                            state      <= S_FILL;
                            byte_ready <= 1'b1;
                        end
                    end
                end
                S_PAD: begin
                    state       <= S_EMIT_PAD;
                    block_valid <= 1'b1;
                    block_last  <= (ptr < PTR_W'(LEN_OFFSET));
                end
                S_EMIT_PAD: begin
                    if (block_ready) begin
                        block_valid <= 1'b0;
                        if (block_last) begin
                            state      <= S_FILL;
                            ptr        <= '0;
                            bitcnt     <= '0;
                            pend_pad   <= 1'b0;
                            byte_ready <= 1'b1;
                            block_last <= 1'b0;
                        end else begin
                            state <= S_EXTRA;
                        end
                    end
                end
                S_EXTRA: begin
                    state       <= S_EMIT_LAST;
                    block_valid <= 1'b1;
                    block_last  <= 1'b1;
                end
                S_EMIT_LAST: begin
                    if (block_ready) begin
                        state       <= S_FILL;
                        ptr         <= '0;
                        bitcnt      <= '0;
                        pend_pad    <= 1'b0;
                        byte_ready  <= 1'b1;
                        block_valid <= 1'b0;
                        block_last  <= 1'b0;
                    end
                end
                default: begin
                    state       <= S_FILL;
                    block_valid <= 1'b0;
                    block_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
